// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master bridge and the team's APB slaves:
//   - APB_ADDR_W / APB_DATA_W : default bus widths
//   - APB_TIMEOUT_DATA        : read data returned when a transfer is aborted
//   - apb_state_e             : bridge transfer state (IDLE/SETUP/ACCESS/RESP)
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Recognisable pattern returned on a wait-state timeout abort.
    localparam logic [31:0] APB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Saturating wait-state counter used by the APB master bridge when the
// APB_TIMEOUT_EN build option is defined.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   clr     in   clear the count (entry into ACCESS)
//   en      in   count one wait cycle (ACCESS with PREADY low)
//   expired out  current cycle is the LIMIT-th wait cycle; if it is counted
//                the limit is reached at the next edge
// -----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_r;

    // Wait counter: clear has priority, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && (count_r != CNT_LIMIT)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Flag the cycle whose wait would bring the count up to LIMIT, so the
    // bridge can abort on that same edge rather than one cycle late.
    assign expired = (count_r == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Single-outstanding APB master: accepts one command on a valid/ready channel,
// runs an APB SETUP/ACCESS transfer and returns the result on a valid/ready
// response channel. All APB outputs and response outputs are registered;
// cmd_ready is decoded from the state register.
//
// Build option:
//   APB_TIMEOUT_EN  when defined, an ACCESS phase that sees TIMEOUT_CYCLES
//                   cycles without PREADY is aborted with rsp_err=1 and
//                   rsp_rdata=APB_TIMEOUT_DATA. When undefined ACCESS waits
//                   on PREADY indefinitely and TIMEOUT_CYCLES does not exist.
//
// Ports:
//   PCLK, PRESETn                      clock / async active-low reset
//   cmd_valid, cmd_ready               command handshake
//   cmd_write, cmd_addr, cmd_wdata     command payload
//   rsp_valid, rsp_ready               response handshake
//   rsp_rdata, rsp_err                 response payload (rdata=0 for writes)
//   PADDR, PSELx, PENABLE, PWRITE,
//   PWDATA                             APB request outputs
//   PRDATA, PREADY, PSLVERR            APB completion inputs
// -----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        state_r,     state_nxt_s;
    logic [ADDR_W-1:0] paddr_r,     paddr_nxt_s;
    logic              pwrite_r,    pwrite_nxt_s;
    logic [DATA_W-1:0] pwdata_r,    pwdata_nxt_s;
    logic              psel_r,      psel_nxt_s;
    logic              penable_r,   penable_nxt_s;
    logic              rsp_valid_r, rsp_valid_nxt_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
    logic              rsp_err_r,   rsp_err_nxt_s;

`ifdef APB_TIMEOUT_EN
    logic timer_clr_s;
    logic timer_en_s;
    logic timer_expired_s;

    apb_wait_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (timer_expired_s)
    );
`endif

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nxt_s     = state_r;
        paddr_nxt_s     = paddr_r;
        pwrite_nxt_s    = pwrite_r;
        pwdata_nxt_s    = pwdata_r;
        psel_nxt_s      = psel_r;
        penable_nxt_s   = penable_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
`ifdef APB_TIMEOUT_EN
        timer_clr_s     = 1'b0;
        timer_en_s      = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                // Address/data are only loaded here, so they stay frozen
                // through SETUP/ACCESS and keep their last value while idle.
                if (cmd_valid) begin
                    paddr_nxt_s   = cmd_addr;
                    pwrite_nxt_s  = cmd_write;
                    pwdata_nxt_s  = cmd_wdata;
                    psel_nxt_s    = 1'b1;
                    penable_nxt_s = 1'b0;
                    state_nxt_s   = SETUP;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            SETUP: begin
                penable_nxt_s = 1'b1;
                state_nxt_s   = ACCESS;
`ifdef APB_TIMEOUT_EN
                timer_clr_s   = 1'b1;
`endif
            end
            ACCESS: begin
                // PREADY wins over a simultaneous timeout.
                if (PREADY) begin
                    rsp_rdata_nxt_s = pwrite_r ? {DATA_W{1'b0}} : PRDATA;
                    rsp_err_nxt_s   = PSLVERR;
                    psel_nxt_s      = 1'b0;
                    penable_nxt_s   = 1'b0;
                    rsp_valid_nxt_s = 1'b1;
                    state_nxt_s     = RESP;
                end else begin
`ifdef APB_TIMEOUT_EN
                    timer_en_s = 1'b1;
                    if (timer_expired_s) begin
                        rsp_rdata_nxt_s = DATA_W'(APB_TIMEOUT_DATA);
                        rsp_err_nxt_s   = 1'b1;
                        psel_nxt_s      = 1'b0;
                        penable_nxt_s   = 1'b0;
                        rsp_valid_nxt_s = 1'b1;
                        state_nxt_s     = RESP;
                    end else begin
                        state_nxt_s     = ACCESS;
                    end
`else
                    state_nxt_s = ACCESS;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s     = RESP;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                psel_nxt_s      = 1'b0;
                penable_nxt_s   = 1'b0;
                rsp_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r     <= IDLE;
            paddr_r     <= {ADDR_W{1'b0}};
            pwrite_r    <= 1'b0;
            pwdata_r    <= {DATA_W{1'b0}};
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            paddr_r     <= paddr_nxt_s;
            pwrite_r    <= pwrite_nxt_s;
            pwdata_r    <= pwdata_nxt_s;
            psel_r      <= psel_nxt_s;
            penable_r   <= penable_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    assign cmd_ready = (state_r == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign PADDR     = paddr_r;
    assign PSELx     = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PWDATA    = pwdata_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Self-checking bench for apb_master_bridge. The bench plays the APB slave
// (a sparse memory) and keeps an independent reference memory indexed by the
// command address; expected timing comes from the transfer rules
// (SETUP 1 cycle, ACCESS = wait states + 1, response until rsp_ready).
// Inputs are driven and outputs sampled on the falling edge of PCLK.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

`ifdef APB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    localparam int TMO_LIMIT = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA = 32'h0;
    logic        PSELx, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] slv_mem   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    logic        nxt_write;
    logic [31:0] nxt_addr, nxt_wdata;

    always #5 PCLK = ~PCLK;

    apb_master_bridge dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // One complete transfer with 'waits' PREADY-low ACCESS cycles and
    // 'rsp_delay' cycles of response backpressure. With 'hold' set, the next
    // command (nxt_*) is presented while the response is still pending.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input int waits, input logic serr, input int rsp_delay,
                           input bit hold);
        bit          abort;
        int          n_acc;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [68:0] got_v, exp_v;
        abort = TMO && (waits >= TMO_LIMIT);
        n_acc = abort ? TMO_LIMIT : waits + 1;
        if (abort) begin
            exp_rd  = 32'hDEAD_BEEF;
            exp_err = 1'b1;
        end else begin
            exp_err = serr;
            exp_rd  = w ? 32'h0 : model_read(a);
            if (w && !serr) model_mem[a] = wd;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
        rsp_ready = 1'($urandom_range(0, 1));
        PREADY    = 1'($urandom_range(0, 1));
        PSLVERR   = 1'($urandom_range(0, 1));
        @(negedge PCLK);
        got_v = {PSELx, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid};
        exp_v = {1'b1, 1'b0, w, a, wd, 1'b0, 1'b0};
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL setup_phase: got %h want %h", got_v, exp_v);
        end
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
        PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'b1; PRDATA = $urandom;
        for (int i = 0; i < n_acc; i++) begin
            @(negedge PCLK);
            got_v = {PSELx, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid};
            exp_v = {1'b1, 1'b1, w, a, wd, 1'b0, 1'b0};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL access_phase cycle %0d: got %h want %h", i, got_v, exp_v);
            end
            cmd_valid = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
            if (!abort && (i == waits)) begin
                PREADY  = 1'b1;
                PSLVERR = serr;
                PRDATA  = slave_read(PADDR);
                if (PWRITE && !serr) slv_mem[PADDR] = PWDATA;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
            end
        end
        for (int k = 0; k <= rsp_delay; k++) begin
            @(negedge PCLK);
            got_v = {rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, cmd_ready, PADDR};
            exp_v = {1'b1, exp_rd, exp_err, 1'b0, 1'b0, 1'b0, a};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL response cycle %0d: got %h want %h", k, got_v, exp_v);
            end
            PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
            if (hold) begin
                cmd_valid = 1'b1; cmd_write = nxt_write;
                cmd_addr = nxt_addr; cmd_wdata = nxt_wdata;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
            end
            rsp_ready = (k == rsp_delay);
        end
        @(negedge PCLK);
        got_v = {rsp_valid, PSELx, PENABLE, cmd_ready, PADDR, PWDATA, PWRITE};
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, a, wd, w};
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL back_to_idle: got %h want %h", got_v, exp_v);
        end
        rsp_ready = 1'($urandom_range(0, 1));
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [103:0] got_v;
        logic [103:0] exp_v;
        exp_v = {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00};
        PRESETn = 1'b0;
        @(negedge PCLK);
        got_v = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSELx, PENABLE, PWRITE, PWDATA, 2'b00};
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL reset_state: got %h want %h", got_v, exp_v);
        end
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        got_v = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PSELx, PENABLE, PWRITE, PWDATA, 2'b00};
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL after_reset_idle: got %h want %h", got_v, exp_v);
        end
    endtask

    task automatic test_zero_wait_write();
        do_xfer(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_wait_states_read();
        slv_mem[32'h0000_0020]   = 32'h0000_0007;
        model_mem[32'h0000_0020] = 32'h0000_0007;
        do_xfer(1'b0, 32'h0000_0020, 32'h1111_2222, 3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        nxt_write = 1'b1; nxt_addr = 32'h0000_0014; nxt_wdata = 32'h1234_5678;
        do_xfer(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 5, 1'b1);
        do_xfer(1'b1, 32'h0000_0014, 32'h1234_5678, 1, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 32'h0000_0014, 32'h0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_slave_error();
        do_xfer(1'b0, 32'h0000_0030, 32'h0, 1, 1'b1, 0, 1'b0);
        do_xfer(1'b1, 32'h0000_0034, 32'hCAFE_F00D, 0, 1'b1, 1, 1'b0);
        do_xfer(1'b0, 32'h0000_0034, 32'h0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_long_wait();
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 15, 1'b0, 0, 1'b0);
        do_xfer(1'b1, 32'h0000_0040, 32'h0BAD_0BAD, 16, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 32'h0000_0044, 32'h0, 20, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic        cw, nw;
        logic [31:0] ca, cd, na, nd;
        cw = 1'b1; ca = 32'h0000_0100; cd = $urandom;
        for (int i = 0; i < 40; i++) begin
            bit h;
            nw = 1'($urandom_range(0, 1));
            na = 32'h0000_0100 + 32'($urandom_range(0, 7)) * 32'd4;
            nd = $urandom;
            h  = (i != 39) && ($urandom_range(0, 1) == 1);
            nxt_write = nw; nxt_addr = na; nxt_wdata = nd;
            do_xfer(cw, ca, cd, int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), h);
            cw = nw; ca = na; cd = nd;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] got_v;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050; PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        got_v = {PSELx, PENABLE, rsp_valid, cmd_ready};
        n_checks++;
        if (got_v !== 4'b1100) begin
            n_errors++;
            $display("FAIL pre_reset_access: got %b want 1100", got_v);
        end
        #2 PRESETn = 1'b0;
        #1 got_v = {PSELx, PENABLE, rsp_valid, cmd_ready};
        n_checks++;
        if (got_v !== 4'b0001) begin
            n_errors++;
            $display("FAIL async_reset: got %b want 0001", got_v);
        end
        @(negedge PCLK);
        PRESETn = 1'b1; PREADY = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            got_v = {PSELx, PENABLE, rsp_valid, cmd_ready};
            n_checks++;
            if (got_v !== 4'b0001) begin
                n_errors++;
                $display("FAIL no_rsp_after_reset cycle %0d: got %b want 0001", i, got_v);
            end
        end
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_states_read();
        test_back_to_back();
        test_slave_error();
        test_long_wait();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
